// File: rtl/mipi_dsi_pkg.sv
// Shared DSI lane definitions: beat geometry and the byte-to-lane map
// used by the transmit distributor and the receive aligner models.
package mipi_dsi_pkg;

   localparam int MAX_LANES  = 4;
   localparam int BYTE_W     = 8;
   localparam int LANE_W     = 16;
   localparam int SLOTS      = LANE_W / BYTE_W;
   localparam int BEAT_FLAGS = 2;
   localparam int CNT_W      = $clog2(MAX_LANES * SLOTS);

   function automatic int lane_of(input int k, input int lanes);
      return k % lanes;
   endfunction

   function automatic int slot_of(input int k, input int lanes);
      return k / lanes;
   endfunction

   function automatic int beat_w(input int lanes);
      return lanes * (LANE_W + SLOTS) + BEAT_FLAGS;
   endfunction

endpackage

// File: rtl/mipi_beat_fifo.sv
// First-word-fall-through beat FIFO with synchronous clear.
// rdata_o always shows the head entry; count/full/empty are registered.
module mipi_beat_fifo #(
   parameter int W     = 38,
   parameter int DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         clr_i,
   input  logic                         push_i,
   input  logic [W-1:0]                 wdata_i,
   input  logic                         pop_i,
   output logic [W-1:0]                 rdata_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         full_o,
   output logic                         empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push;
   logic          do_pop;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = nxt(wr_q);
      if (do_pop)  rd_d = nxt(rd_q);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/mipi_lane_distributor.sv
// Spreads a serial packet byte stream across DSI lanes as 16-bit beats,
// tagging first/last beats for SoT/EoT generation in the serializers.
module mipi_lane_distributor
   import mipi_dsi_pkg::*;
#(
   parameter int LANES     = 2,
   parameter int OUT_DEPTH = 4
) (
   input  logic                  byte_clk,
   input  logic                  sys_rst,
   input  logic                  dist_flush,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [LANES*16-1:0]   out_data,
   output logic [LANES-1:0]      out_lane_valid,
   output logic [LANES*2-1:0]    out_byte_en,
   output logic                  out_first,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

   localparam int NB = LANES * SLOTS;
   localparam int DW = LANES * LANE_W;
   localparam int BW = LANES * SLOTS;
   localparam int FW = beat_w(LANES);
   localparam int CW = $clog2(OUT_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NB - 1);

   logic             clr;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    stg_q, stg_d, stg_ins;
   logic [BW-1:0]    be_q, be_d, be_ins;
   logic             fp_q, fp_d;
   logic             accept;
   logic             close;
   logic [FW-1:0]    head;
   logic [CW-1:0]    f_count;
   logic             f_full;
   logic             f_empty;
   logic             show;

   assign clr      = sys_rst | dist_flush;
   assign in_ready = ~clr & ~f_full;
   assign accept   = in_valid & in_ready;
   assign close    = accept & ((cnt_q == CNT_MAX) | in_last);

   // Staging word with the incoming byte dropped into its lane/slot.
   always_comb begin
      stg_ins = stg_q;
      be_ins  = be_q;
      for (int k = 0; k < NB; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            stg_ins[lane_of(k, LANES)*LANE_W + slot_of(k, LANES)*BYTE_W +: BYTE_W] = in_data;
            be_ins[lane_of(k, LANES)*SLOTS + slot_of(k, LANES)] = 1'b1;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      stg_d = stg_q;
      be_d  = be_q;
      fp_d  = fp_q;
      if (accept) begin
         if (close) begin
            cnt_d = '0;
            stg_d = '0;
            be_d  = '0;
            fp_d  = in_last;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
            stg_d = stg_ins;
            be_d  = be_ins;
         end
      end
   end

   always_ff @(posedge byte_clk) begin
      if (clr) begin
         cnt_q <= '0;
         stg_q <= '0;
         be_q  <= '0;
         fp_q  <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         stg_q <= stg_d;
         be_q  <= be_d;
         fp_q  <= fp_d;
      end
   end

   mipi_beat_fifo #(
      .W     (FW),
      .DEPTH (OUT_DEPTH)
   ) u_fifo (
      .clk_i   (byte_clk),
      .clr_i   (clr),
      .push_i  (close),
      .wdata_i ({fp_q, in_last, be_ins, stg_ins}),
      .pop_i   (out_ready & ~f_empty),
      .rdata_o (head),
      .count_o (f_count),
      .full_o  (f_full),
      .empty_o (f_empty)
   );

   // Outputs read as zero whenever no beat is presented or a clear is active.
   assign show        = ~clr & (f_count != '0);
   assign out_valid   = show;
   assign out_first   = show & head[FW-1];
   assign out_last    = show & head[FW-2];
   assign out_byte_en = head[DW +: BW] & {BW{show}};
   assign out_data    = head[DW-1:0] & {DW{show}};
   assign busy        = ~clr & ((cnt_q != '0) | ~fp_q | (f_count != '0));

   always_comb begin
      out_lane_valid = '0;
      for (int l = 0; l < LANES; l++) begin
         out_lane_valid[l] = out_byte_en[2*l];
      end
   end

endmodule

// File: tb/tb_mipi_lane_distributor.sv
// Random and directed stimulus on 2-lane and 4-lane distributors,
// checked against a packet-level beat model.
module tb_mipi_lane_distributor;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic [7:0] din = '0;
   logic       dv = 1'b0;
   logic       dl = 1'b0;
   logic       ordy = 1'b0;

   always #5 clk = ~clk;

   logic        ir_a, of_a, ol_a, ov_a, bz_a;
   logic [31:0] od_a;
   logic [1:0]  lv_a;
   logic [3:0]  be_a;
   logic        ir_b, of_b, ol_b, ov_b, bz_b;
   logic [63:0] od_b;
   logic [3:0]  lv_b;
   logic [7:0]  be_b;

   mipi_lane_distributor #(.LANES(2), .OUT_DEPTH(D)) u_a (
      .byte_clk(clk), .sys_rst(rst), .dist_flush(flush),
      .in_data(din), .in_valid(dv), .in_last(dl), .in_ready(ir_a),
      .out_data(od_a), .out_lane_valid(lv_a), .out_byte_en(be_a),
      .out_first(of_a), .out_last(ol_a), .out_valid(ov_a),
      .out_ready(ordy), .busy(bz_a)
   );

   mipi_lane_distributor #(.LANES(4), .OUT_DEPTH(D)) u_b (
      .byte_clk(clk), .sys_rst(rst), .dist_flush(flush),
      .in_data(din), .in_valid(dv), .in_last(dl), .in_ready(ir_b),
      .out_data(od_b), .out_lane_valid(lv_b), .out_byte_en(be_b),
      .out_first(of_b), .out_last(ol_b), .out_valid(ov_b),
      .out_ready(ordy), .busy(bz_b)
   );

   logic [63:0] od [2];
   logic [7:0]  be [2];
   logic [3:0]  lv [2];
   logic        ir [2];
   logic        of [2];
   logic        ol [2];
   logic        ov [2];
   logic        bz [2];

   assign od[0] = {32'd0, od_a};
   assign od[1] = od_b;
   assign be[0] = {4'd0, be_a};
   assign be[1] = be_b;
   assign lv[0] = {2'd0, lv_a};
   assign lv[1] = lv_b;
   assign ir[0] = ir_a;
   assign ir[1] = ir_b;
   assign of[0] = of_a;
   assign of[1] = of_b;
   assign ol[0] = ol_a;
   assign ol[1] = ol_b;
   assign ov[0] = ov_a;
   assign ov[1] = ov_b;
   assign bz[0] = bz_a;
   assign bz[1] = bz_b;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  be;
      logic [3:0]  lv;
      logic        f;
      logic        l;
   } beat_t;

   beat_t      eq [2][$];
   logic [7:0] sb [2][$];
   bit         fp [2] = '{1'b1, 1'b1};
   int         errs = 0;
   int         checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ln(input int i);
      return (i != 0) ? 4 : 2;
   endfunction

   // A packet byte lands in lane k%L, slot k/L of its beat.
   task automatic feed(input int i, input logic [7:0] b, input bit last);
      beat_t bt;
      int    n;
      int    L;
      L = ln(i);
      sb[i].push_back(b);
      if (sb[i].size() == 2 * L || last) begin
         bt = '0;
         n  = sb[i].size();
         for (int k = 0; k < n; k++) begin
            bt.d[(k % L) * 16 + (k / L) * 8 +: 8] = sb[i][k];
            bt.be[(k % L) * 2 + (k / L)] = 1'b1;
         end
         for (int l = 0; l < L; l++) bt.lv[l] = (n > l);
         bt.f  = fp[i];
         bt.l  = last;
         fp[i] = last;
         eq[i].push_back(bt);
         sb[i].delete();
      end
   endtask

   always @(negedge clk) begin : mon
      bit    c;
      bit    xir;
      beat_t h;
      for (int i = 0; i < 2; i++) begin
         c   = rst || flush;
         xir = !c && (eq[i].size() < D);
         chk($sformatf("in_ready/%0d", i), ir[i], xir);
         chk($sformatf("out_valid/%0d", i), ov[i], !c && eq[i].size() != 0);
         chk($sformatf("busy/%0d", i), bz[i],
             !c && (sb[i].size() != 0 || !fp[i] || eq[i].size() != 0));
         if (c) begin
            chk($sformatf("clr_data/%0d", i), od[i], 64'd0);
            chk($sformatf("clr_flags/%0d", i), {be[i], of[i], ol[i]}, 64'd0);
            eq[i].delete();
            sb[i].delete();
            fp[i] = 1'b1;
         end else begin
            if (eq[i].size() != 0) begin
               h = eq[i][0];
               chk($sformatf("data/%0d", i), od[i], h.d);
               chk($sformatf("byte_en/%0d", i), be[i], h.be);
               chk($sformatf("lane_valid/%0d", i), lv[i], h.lv);
               chk($sformatf("first_last/%0d", i), {of[i], ol[i]}, {h.f, h.l});
               if (ordy) void'(eq[i].pop_front());
            end
            if (dv && xir) feed(i, din, dl);
         end
      end
   end

   task automatic send(input logic [7:0] b, input bit l);
      din = b;
      dv  = 1'b1;
      dl  = l;
      @(posedge clk);
      #1;
      dv  = 1'b0;
      dl  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst  = 1'b0;
      ordy = 1'b1;

      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
      chk("tp1_data", od[0], 64'h4422_3311);
      chk("tp1_be_lv", {be[0], lv[0]}, {8'h0F, 4'h3});
      chk("tp1_fl", {ov[0], of[0], ol[0]}, 3'b111);
      idle(3);

      for (int k = 0; k < 4; k++) send(8'hA0 + 8'(k), 0);
      chk("tp2_b1_data", od[0], 64'hA3A1_A2A0);
      chk("tp2_b1_fl", {be[0], of[0], ol[0]}, {8'h0F, 2'b10});
      send(8'hA4, 1);
      chk("tp2_b2_data", od[0], 64'h0000_00A4);
      chk("tp2_b2_be_lv", {be[0], lv[0]}, {8'h01, 4'h1});
      chk("tp2_b2_fl", {of[0], ol[0]}, 2'b01);
      idle(3);

      send(8'h5A, 1);
      chk("tp3_a", {od[0][7:0], be[0], of[0], ol[0]}, {8'h5A, 8'h01, 2'b11});
      send(8'h6B, 1);
      chk("tp3_b", {od[0][7:0], be[0], of[0], ol[0]}, {8'h6B, 8'h01, 2'b11});
      idle(2);
      chk("tp3_idle", {bz[0], bz[1]}, 2'b00);

      for (int k = 0; k < 8; k++) send(8'(k), k == 7);
      chk("tp6_data8", od[1], 64'h0703_0602_0501_0400);
      chk("tp6_be8", be[1], 8'hFF);
      idle(2);
      for (int k = 0; k < 6; k++) send(8'h10 + 8'(k), k == 5);
      chk("tp6_data6", od[1], 64'h0013_0012_1511_1410);
      chk("tp6_be6", {be[1], lv[1]}, {8'h5F, 4'hF});
      idle(3);

      send(8'hC0, 0); send(8'hC1, 0); send(8'hC2, 0);
      flush = 1'b1;
      #1;
      chk("tp5_flush", {ir[0], ov[0], ir[1], ov[1]}, 4'b0000);
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("tp5_busy", {bz[0], bz[1]}, 2'b00);
      for (int k = 0; k < 4; k++) send(8'hD0 + 8'(k), k == 3);
      chk("tp5_data", od[0], 64'hD3D1_D2D0);
      chk("tp5_first", {of[0], of[1]}, 2'b11);
      idle(3);

      ordy = 1'b0;
      for (int k = 0; k < 4 * D; k++) send(8'h40 + 8'(k), 0);
      chk("tp4_full", {ir[0], ov[0], ir[1]}, 3'b011);
      ordy = 1'b1;
      #1;
      chk("tp4_hold", ir[0], 1'b0);
      idle(1);
      chk("tp4_rise", ir[0], 1'b1);
      idle(10);

      for (int n = 0; n < 3000; n++) begin
         din   = 8'($urandom);
         dv    = ($urandom % 10) < 7;
         dl    = ($urandom % 6) == 0;
         ordy  = ($urandom % 10) < 6;
         flush = ($urandom % 150) == 0;
         rst   = ($urandom % 400) == 0;
         @(posedge clk);
         #1;
      end
      dv    = 1'b0;
      dl    = 1'b0;
      flush = 1'b0;
      rst   = 1'b0;
      ordy  = 1'b1;
      idle(10);
      send(8'hEE, 1);
      idle(10);
      chk("final_idle", {bz[0], bz[1], ov[0], ov[1]}, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
